// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: captures retired instructions into a FWFT trace FIFO and
// tracks end-of-test (marker, overflow, idle timeout) for the harness.
module commit_trace_fifo #(
   parameter int XLEN    = 32,
   parameter int NRET    = 2,
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NRET-1:0]            ret_valid,
   input  logic [NRET*XLEN-1:0]       ret_pc,
   input  logic [NRET*32-1:0]         ret_instr,
   input  logic [NRET*5-1:0]          ret_rd,
   input  logic [NRET*XLEN-1:0]       ret_rd_val,
   input  logic [NRET-1:0]            ret_wr,
   input  logic [XLEN-1:0]            v0_val,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [XLEN-1:0]            out_pc,
   output logic [31:0]                out_instr,
   output logic [4:0]                 out_rd,
   output logic [XLEN-1:0]            out_rd_val,
   output logic                       out_wr,
   output logic [31:0]                out_seq,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [1:0]                 state,
   output logic                       overflow,
   output logic                       timeout,
   output logic                       pass
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int IW = $clog2(TIMEOUT+1);

   typedef enum logic [1:0] {RUN, DRAIN, DONE, ERROR} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]   count_q, count_d, n_valid, n_enq, free;
   logic [31:0]     seq_q, seq_d;
   logic [IW-1:0]   idle_q, idle_d;
   logic            overflow_q, overflow_d, timeout_q, timeout_d, pass_q, pass_d;
   logic [NRET-1:0] keep, wen;
   logic [CW-1:0]   wofs [NRET];
   logic [AW-1:0]   waddr [NRET];
   logic            marker, ovf, deq;

   logic [XLEN-1:0] pc_mem  [DEPTH];
   logic [31:0]     ins_mem [DEPTH];
   logic [4:0]      rd_mem  [DEPTH];
   logic [XLEN-1:0] val_mem [DEPTH];
   logic            wr_mem  [DEPTH];
   logic [31:0]     seq_mem [DEPTH];

   always_comb begin
      keep    = '0;
      marker  = 1'b0;
      n_valid = '0;
      // lanes younger than an end marker are discarded
      for (int i = 0; i < NRET; i++) begin
         wofs[i]  = n_valid;
         waddr[i] = wptr_q + AW'(n_valid);
         if (!marker && ret_valid[i]) begin
            keep[i] = 1'b1;
            n_valid = n_valid + CW'(1);
            if (ret_instr[i*32 +: 32] == 32'h0000_000C && v0_val == XLEN'('hA)) marker = 1'b1;
         end
      end
      free       = CW'(DEPTH) - count_q;
      ovf        = state_q == RUN && n_valid > free;
      wen        = (state_q == RUN && !ovf) ? keep : '0;
      n_enq      = (state_q == RUN && !ovf) ? n_valid : '0;
      deq        = count_q != '0 && out_ready;
      count_d    = count_q + n_enq - CW'(deq);
      wptr_d     = wptr_q + AW'(n_enq);
      rptr_d     = rptr_q + AW'(deq);
      seq_d      = seq_q + 32'(n_enq);
      idle_d     = idle_q;
      state_d    = state_q;
      overflow_d = overflow_q;
      timeout_d  = timeout_q;
      pass_d     = pass_q;
      if (state_q == RUN) begin
         idle_d = ret_valid == '0 ? idle_q + IW'(1) : '0;
         if (ovf) begin
            overflow_d = 1'b1;
            state_d    = ERROR;
         end else if (marker) begin
            state_d = DRAIN;
         end else if (idle_d == IW'(TIMEOUT)) begin
            timeout_d = 1'b1;
            state_d   = ERROR;
         end
      end else if (state_q == DRAIN && count_d == '0) begin
         state_d = DONE;
         pass_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= RUN;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         seq_q      <= '0;
         idle_q     <= '0;
         overflow_q <= 1'b0;
         timeout_q  <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         seq_q      <= seq_d;
         idle_q     <= idle_d;
         overflow_q <= overflow_d;
         timeout_q  <= timeout_d;
         pass_q     <= pass_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NRET; i++) begin
         if (wen[i]) begin
            pc_mem[waddr[i]]  <= ret_pc[i*XLEN +: XLEN];
            ins_mem[waddr[i]] <= ret_instr[i*32 +: 32];
            rd_mem[waddr[i]]  <= ret_rd[i*5 +: 5];
            val_mem[waddr[i]] <= ret_rd_val[i*XLEN +: XLEN];
            wr_mem[waddr[i]]  <= ret_wr[i];
            seq_mem[waddr[i]] <= seq_q + 32'(wofs[i]);
         end
      end
   end

   assign out_valid  = count_q != '0;
   assign out_pc     = pc_mem[rptr_q];
   assign out_instr  = ins_mem[rptr_q];
   assign out_rd     = rd_mem[rptr_q];
   assign out_rd_val = val_mem[rptr_q];
   assign out_wr     = wr_mem[rptr_q];
   assign out_seq    = seq_mem[rptr_q];
   assign count      = count_q;
   assign state      = state_q;
   assign overflow   = overflow_q;
   assign timeout    = timeout_q;
   assign pass       = pass_q;
endmodule

// File: tb/tb_commit_trace_fifo.sv
// tb_commit_trace_fifo: directed checks of the commit trace FIFO with a short
// idle timeout so the timeout path is reachable quickly.
module tb_commit_trace_fifo;
   logic        clk, reset;
   logic [1:0]  ret_valid, ret_wr;
   logic [63:0] ret_pc, ret_instr, ret_rd_val;
   logic [9:0]  ret_rd;
   logic [31:0] v0_val;
   logic        out_valid, out_ready, out_wr, overflow, timeout, pass;
   logic [31:0] out_pc, out_instr, out_rd_val, out_seq;
   logic [4:0]  out_rd, count;
   logic [1:0]  state;
   int          n_tests = 0, n_fail = 0;

   commit_trace_fifo #(.XLEN(32), .NRET(2), .DEPTH(16), .TIMEOUT(8)) dut (
      .clk(clk), .reset(reset), .ret_valid(ret_valid), .ret_pc(ret_pc),
      .ret_instr(ret_instr), .ret_rd(ret_rd), .ret_rd_val(ret_rd_val),
      .ret_wr(ret_wr), .v0_val(v0_val), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .out_rd(out_rd), .out_rd_val(out_rd_val), .out_wr(out_wr),
      .out_seq(out_seq), .count(count), .state(state), .overflow(overflow),
      .timeout(timeout), .pass(pass)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_lane(input int i, input logic [31:0] pc, input logic [31:0] ins);
      ret_pc[i*32 +: 32]     = pc;
      ret_instr[i*32 +: 32]  = ins;
      ret_rd[i*5 +: 5]       = 5'(i + 1);
      ret_rd_val[i*32 +: 32] = pc ^ 32'hffff_0000;
      ret_wr[i]              = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      ret_valid = '0;
      out_ready = 1'b0;
      v0_val    = '0;
      reset     = 1'b0;
      #2;
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b1;
      ret_valid = '0; ret_wr = '0; ret_pc = '0; ret_instr = '0;
      ret_rd = '0; ret_rd_val = '0; v0_val = '0; out_ready = 1'b0;
      do_reset();
      check("rst_count", count, 0);
      check("rst_valid", out_valid, 0);
      check("rst_state", state, 0);
      check("rst_flags", {overflow, timeout, pass}, 0);

      // two single-lane retires, consumer always ready
      out_ready = 1'b1;
      set_lane(0, 32'h100, 32'h13);
      set_lane(1, 32'h104, 32'h13);
      ret_valid = 2'b01;
      step();
      check("r1_valid", out_valid, 1);
      check("r1_pc", out_pc, 32'h100);
      check("r1_seq", out_seq, 0);
      check("r1_rd", {out_rd, out_rd_val, out_wr}, {5'd1, 32'hffff0100, 1'b1});
      ret_valid = 2'b10;
      step();
      check("r2_pc", out_pc, 32'h104);
      check("r2_seq", out_seq, 1);
      check("r2_count", count, 1);
      ret_valid = 2'b00;
      step();
      check("r3_empty", {out_valid, count}, 0);

      // fill to DEPTH then overflow by one lane
      do_reset();
      for (int k = 0; k < 8; k++) begin
         set_lane(0, 32'h200 + 32'(k * 8), 32'h13);
         set_lane(1, 32'h204 + 32'(k * 8), 32'h13);
         ret_valid = 2'b11;
         step();
      end
      check("full_count", count, 16);
      check("full_ovf", overflow, 0);
      check("full_state", state, 0);
      check("full_head", {out_pc, out_seq}, {32'h200, 32'd0});
      ret_valid = 2'b01;
      step();
      check("ovf_flag", overflow, 1);
      check("ovf_state", state, 3);
      check("ovf_count", count, 16);
      out_ready = 1'b1;
      ret_valid = 2'b11;
      step();
      check("err_drain_count", count, 15);
      check("err_drain_head", {out_pc, out_seq}, {32'h204, 32'd1});
      check("err_pass", pass, 0);

      // same-cycle dequeue does not create space
      do_reset();
      for (int k = 0; k < 7; k++) begin
         ret_valid = 2'b11;
         step();
      end
      ret_valid = 2'b01;
      step();
      check("f15_count", count, 15);
      out_ready = 1'b1;
      ret_valid = 2'b11;
      step();
      check("deq_nospace_ovf", overflow, 1);
      check("deq_nospace_count", count, 14);
      check("deq_nospace_state", state, 3);

      // end marker in lane 0, lane 1 discarded
      do_reset();
      out_ready = 1'b1;
      set_lane(0, 32'h300, 32'h0000_000C);
      set_lane(1, 32'h304, 32'h13);
      v0_val    = 32'hA;
      ret_valid = 2'b11;
      step();
      check("mk_state", state, 1);
      check("mk_count", count, 1);
      check("mk_head", {out_pc, out_seq}, {32'h300, 32'd0});
      step();
      check("mk_done", {state, pass, count}, {2'd2, 1'b1, 5'd0});
      step();
      check("mk_hold", {state, pass, count, out_valid}, {2'd2, 1'b1, 5'd0, 1'b0});

      // ordinary 0xC with v0 != A, then reset mid-drain at count=5
      do_reset();
      set_lane(0, 32'h400, 32'h0000_000C);
      set_lane(1, 32'h404, 32'h13);
      v0_val    = 32'h9;
      ret_valid = 2'b11;
      step();
      check("nomk_state", {state, count}, {2'd0, 5'd2});
      step();
      v0_val    = 32'hA;
      ret_valid = 2'b01;
      step();
      check("d5_state", {state, count}, {2'd1, 5'd5});
      ret_valid = 2'b00;
      reset = 1'b0;
      #1;
      check("rst_mid_drain", {count, out_valid, state, pass}, 0);
      #1;
      reset = 1'b1;
      out_ready = 1'b1;
      v0_val    = 32'h0;
      set_lane(0, 32'h500, 32'h13);
      ret_valid = 2'b01;
      step();
      check("post_rst_head", {out_pc, out_seq}, {32'h500, 32'd0});

      // idle timeout
      do_reset();
      for (int k = 0; k < 7; k++) step();
      check("idle7", {timeout, state}, {1'b0, 2'd0});
      step();
      check("idle8", {timeout, state}, {1'b1, 2'd3});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/commit_trace_fifo.md
COMMIT_TRACE_FIFO -- requirements
Module: commit_trace_fifo

Interface
REQ-001 Parameters:
  - XLEN, 32, data/PC width.
  - NRET, 2, retire lanes per cycle (1..2).
  - DEPTH, 16, record slots (power of 2, >=4).
  - TIMEOUT, 1024, idle-cycle limit (>=2).
REQ-002 Ports, one per line:
  - clk  in  1  rising-edge clock.
  - reset  in  1  asynchronous, active-low reset.
  - ret_valid  in  NRET  lane retired an instruction this cycle.
  - ret_pc  in  NRET*XLEN  lane PC.
  - ret_instr  in  NRET*32  lane instruction word.
  - ret_rd  in  NRET*5  lane destination register index.
  - ret_rd_val  in  NRET*XLEN  lane destination write value.
  - ret_wr  in  NRET  lane wrote the register file.
  - v0_val  in  XLEN  architectural $2 value at this cycle's retire point.
  - out_valid  out  1  head record available.
  - out_ready  in  1  consumer accepts head.
  - out_pc, out_instr, out_rd, out_rd_val, out_wr  out  XLEN/32/5/XLEN/1  head record fields.
  - out_seq  out  32  retire sequence number of head record.
  - count  out  clog2(DEPTH+1)  occupied slots.
  - state  out  2  RUN=0, DRAIN=1, DONE=2, ERROR=3.
  - overflow  out  1  sticky: records dropped.
  - timeout  out  1  sticky: idle limit hit.
  - pass  out  1  end-of-test reached cleanly.

Function
REQ-003 Lane 0 is older than lane 1; accepted records are enqueued in lane order into consecutive slots, skipping invalid lanes.
REQ-004 Each enqueued record is tagged with a sequence number from a 32-bit counter, starting at 0 and incremented per record; it wraps modulo 2^32.
REQ-005 The FIFO is first-word fall-through: out_valid = (count != 0), and out_* show the head record.
REQ-006 A record retired in cycle N into an empty FIFO appears at out_* in cycle N+1.
REQ-007 A dequeue occurs when out_valid && out_ready; out_* are don't-care while out_valid=0.
REQ-008 Free space is computed as DEPTH-count at the start of the cycle; a same-cycle dequeue does not add space.
REQ-009 If the number of valid lanes exceeds free space, all of that cycle's records are dropped (none partially enqueued), overflow is set, and state goes to ERROR.
REQ-010 Simultaneous enqueue and dequeue update count by (enqueued - dequeued); read and write pointers wrap modulo DEPTH.
REQ-011 RUN state:
  - Records are accepted.
  - A lane with ret_instr == 32'h0000000C and v0_val == 'hA is the end marker.
  - The end-marker record is enqueued if space allows.
  - Younger lanes in the same cycle are discarded.
  - Next state is DRAIN.
REQ-012 An end marker with v0_val != 'hA is an ordinary record.
REQ-013 RUN idle counter:
  - Counts consecutive cycles with ret_valid == 0.
  - Cleared on any valid lane.
  - On reaching TIMEOUT, sets timeout and goes to ERROR.
REQ-014 DRAIN state:
  - All ret_valid are ignored.
  - The FIFO drains via the handshake.
  - When count reaches 0, go to DONE and set pass=1.
REQ-015 DONE: pass stays 1 and retires are ignored, until reset.
REQ-016 ERROR:
  - Retires are ignored.
  - Draining continues.
  - pass stays 0.
  - State is held until reset.
REQ-017 Overflow and end marker in the same cycle: overflow wins, next state is ERROR.

Reset
REQ-018 Asserting reset (low) asynchronously clears:
  - pointers, count, sequence and idle counters;
  - overflow, timeout and pass;
  - state to RUN; out_valid to 0.
REQ-019 Reset mid-drain discards all stored records.
REQ-020 Deassertion takes effect at the next rising edge of clk.
REQ-021 Storage contents need no reset.

Verification
REQ-022 Lane 0 retires pc=0x100, then lane 1 only retires pc=0x104, with out_ready=1 -> out_pc 0x100 seq 0, then 0x104 seq 1, one cycle after each retire.
REQ-023 With out_ready=0, 8 cycles of both lanes valid (DEPTH=16) -> count=16, no overflow.
REQ-024 Continuing REQ-023, one more valid lane -> overflow=1, state=ERROR, count stays 16.
REQ-025 Both lanes valid, lane 0 instr=0xC with v0_val=0xA, out_ready=1 -> lane 1 discarded, state DRAIN, then DONE with pass=1 once count=0.
REQ-026 TIMEOUT=8 with no retires after reset -> timeout=1 and state=ERROR on the 8th idle cycle.
REQ-027 Reset pulsed while count=5 in DRAIN -> count=0, out_valid=0, state=RUN, pass=0 immediately.
